// File: rtl/puf_verifier.sv
// puf_verifier: issues challenges to the PUF array, then either enrolls the
// response as the golden reference or authenticates it by serial Hamming distance.
// Ports:
//   clk, rst        - system clock, async active-high reset
//   req, enroll     - operation request and mode (1 = enroll, 0 = authenticate)
//   chal_in         - challenge captured with an enroll request
//   puf_start       - one-cycle launch pulse to the PUF array
//   puf_challenge   - challenge driven to the PUF array
//   puf_response    - PUF array response
//   busy, done      - activity flag and one-cycle completion pulse
//   pass, error     - verdict and "no enrollment" flag, held until next request
//   distance        - Hamming distance of the last authentication
//   enrolled        - a reference pair is stored
module puf_verifier #(
    parameter int N           = 128,
    parameter int WAIT_CYCLES = 16,
    parameter int THRESH      = 12,
    parameter int DW          = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          enroll,
    input  logic [N-1:0]  chal_in,
    output logic          puf_start,
    output logic [N-1:0]  puf_challenge,
    input  logic [N-1:0]  puf_response,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          error,
    output logic [DW-1:0] distance,
    output logic          enrolled
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [DW-1:0] THRESH_D  = DW'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          mode_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] acc_q;
    logic [N-1:0]  cap_resp_q;
    logic [N-1:0]  ref_resp_q;
    logic [N-1:0]  ref_chal_q;
    logic [N-1:0]  chal_q;
    logic          enrolled_q;
    logic          start_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          error_q;
    logic [DW-1:0] dist_q;

    logic          diff_bit;
    logic [DW-1:0] acc_d;

    // Accumulator value including the bit being compared this cycle
    always_comb begin
        diff_bit = cap_resp_q[idx_q] ^ ref_resp_q[idx_q];
        acc_d    = acc_q + DW'(diff_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            cap_resp_q <= '0;
            ref_resp_q <= '0;
            ref_chal_q <= '0;
            chal_q     <= '0;
            enrolled_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            error_q    <= 1'b0;
            dist_q     <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        busy_q  <= 1'b1;
                        mode_q  <= enroll;
                        pass_q  <= 1'b0;
                        error_q <= 1'b0;
                        dist_q  <= '0;
                        if (enroll) begin
                            chal_q  <= chal_in;
                            start_q <= 1'b1;
                            state_q <= S_LAUNCH;
                        end else if (enrolled_q) begin
                            chal_q  <= ref_chal_q;
                            start_q <= 1'b1;
                            state_q <= S_LAUNCH;
                        end else begin
                            // Nothing to compare against: report at once
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_LAUNCH: begin
                    cnt_q   <= WAIT_LOAD;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    cap_resp_q <= puf_response;
                    if (mode_q) begin
                        ref_resp_q <= puf_response;
                        ref_chal_q <= chal_q;
                        enrolled_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        // Verdict registered so it appears with done
                        dist_q  <= acc_d;
                        pass_q  <= (acc_d <= THRESH_D);
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign puf_start     = start_q;
    assign puf_challenge = chal_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign error         = error_q;
    assign distance      = dist_q;
    assign enrolled      = enrolled_q;

endmodule

// File: tb/tb_puf_verifier.sv
// tb_puf_verifier: directed, table-driven bench for puf_verifier
// with hand-written sequences for ignored requests and mid-operation reset.
module tb_puf_verifier;

    localparam int N    = 128;
    localparam int WAIT = 16;
    localparam int DW   = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic          req;
    logic          enroll;
    logic [N-1:0]  chal_in;
    logic          puf_start;
    logic [N-1:0]  puf_challenge;
    logic [N-1:0]  puf_response;
    logic          busy;
    logic          done;
    logic          pass;
    logic          error;
    logic [DW-1:0] distance;
    logic          enrolled;

    puf_verifier #(
        .N(N),
        .WAIT_CYCLES(WAIT),
        .THRESH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .enroll(enroll),
        .chal_in(chal_in),
        .puf_start(puf_start),
        .puf_challenge(puf_challenge),
        .puf_response(puf_response),
        .busy(busy),
        .done(done),
        .pass(pass),
        .error(error),
        .distance(distance),
        .enrolled(enrolled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [127:0] chal;
        logic [127:0] resp;
        logic [127:0] exp_chal;
        int           exp_done;
        int           exp_starts;
        logic         exp_pass;
        logic         exp_err;
        int           exp_dist;
        logic         exp_enr;
    } vec_t;

    vec_t vecs[10];

    int n_cmp;
    int n_bad;

    int done_cyc;
    int done_cnt;
    int start_cnt;
    int start_cyc;
    int chal_bad;
    logic timeout;

    logic [127:0] R;
    logic [127:0] A5;
    logic [127:0] C3;
    logic [127:0] M5;
    logic [127:0] M12;
    logic [127:0] M13;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, 128'(busy), 128'd0);
        check({tag, " done"}, 128'(done), 128'd0);
        check({tag, " pass"}, 128'(pass), 128'd0);
        check({tag, " error"}, 128'(error), 128'd0);
        check({tag, " puf_start"}, 128'(puf_start), 128'd0);
        check({tag, " enrolled"}, 128'(enrolled), 128'd0);
        check({tag, " distance"}, 128'(distance), 128'd0);
        check({tag, " puf_challenge"}, puf_challenge, 128'd0);
    endtask

    // One operation; cycle c is observed at the falling edge before edge c.
    // The correct response is presented only around the capture edge.
    task automatic run_op(input logic en, input logic [127:0] chal,
                          input logic [127:0] resp, input int pulse_cyc,
                          input logic [127:0] exp_chal);
        @(negedge clk);
        req          = 1'b1;
        enroll       = en;
        chal_in      = chal;
        puf_response = ~resp;
        @(posedge clk);
        #1;
        req       = 1'b0;
        chal_in   = '0;
        done_cyc  = -1;
        done_cnt  = 0;
        start_cnt = 0;
        start_cyc = -1;
        chal_bad  = 0;
        timeout   = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (puf_start) begin
                start_cnt++;
                start_cyc = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy && puf_challenge !== exp_chal) chal_bad++;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            puf_response = (c == WAIT + 2) ? resp : ~resp;
            if (c == pulse_cyc) begin
                req     = 1'b1;
                enroll  = 1'b1;
                chal_in = '0;
            end else begin
                req = 1'b0;
            end
        end
        req = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        string t;
        t = $sformatf("v%0d", i);
        run_op(vecs[i].en, vecs[i].chal, vecs[i].resp, -1, vecs[i].exp_chal);
        check({t, " timeout"}, 128'(timeout), 128'd0);
        check({t, " done_cycle"}, 128'(done_cyc), 128'(vecs[i].exp_done));
        check({t, " done_count"}, 128'(done_cnt), 128'd1);
        check({t, " start_count"}, 128'(start_cnt), 128'(vecs[i].exp_starts));
        if (vecs[i].exp_starts > 0)
            check({t, " start_cycle"}, 128'(start_cyc), 128'd1);
        check({t, " chal_stable"}, 128'(chal_bad), 128'd0);
        // Results must hold while idle regardless of inputs
        repeat (3) begin
            @(negedge clk);
            puf_response = {$urandom, $urandom, $urandom, $urandom};
            chal_in      = {$urandom, $urandom, $urandom, $urandom};
        end
        check({t, " pass"}, 128'(pass), 128'(vecs[i].exp_pass));
        check({t, " error"}, 128'(error), 128'(vecs[i].exp_err));
        check({t, " distance"}, 128'(distance), 128'(vecs[i].exp_dist));
        check({t, " enrolled"}, 128'(enrolled), 128'(vecs[i].exp_enr));
        check({t, " idle_chal"}, puf_challenge, vecs[i].exp_chal);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        R   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        A5  = {16{8'hA5}};
        C3  = {16{8'h3C}};
        M5  = 128'h8000_0000_0000_0001_0000_0100_0001_0001;
        M12 = 128'h0000_0FFF_0000_0000_0000_0000_0000_0000;
        M13 = 128'hF000_0000_0000_0000_0000_0000_0000_01FF;

        vecs[0] = '{1'b0, '1, R, '0, 1, 0, 1'b0, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b1, A5, R, A5, 19, 1, 1'b0, 1'b0, 0, 1'b1};
        vecs[2] = '{1'b0, '1, R, A5, 147, 1, 1'b1, 1'b0, 0, 1'b1};
        vecs[3] = '{1'b0, '0, R ^ M5, A5, 147, 1, 1'b1, 1'b0, 5, 1'b1};
        vecs[4] = '{1'b0, '0, R ^ M13, A5, 147, 1, 1'b0, 1'b0, 13, 1'b1};
        vecs[5] = '{1'b0, '0, ~R, A5, 147, 1, 1'b0, 1'b0, 128, 1'b1};
        vecs[6] = '{1'b0, '0, R ^ M12, A5, 147, 1, 1'b1, 1'b0, 12, 1'b1};
        vecs[7] = '{1'b1, C3, ~R, C3, 19, 1, 1'b0, 1'b0, 0, 1'b1};
        vecs[8] = '{1'b0, '0, ~R, C3, 147, 1, 1'b1, 1'b0, 0, 1'b1};
        vecs[9] = '{1'b0, '0, R, C3, 147, 1, 1'b0, 1'b0, 128, 1'b1};

        rst          = 1'b1;
        req          = 1'b0;
        enroll       = 1'b0;
        chal_in      = '0;
        puf_response = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) apply_vec(i);

        // A request arriving mid-operation must be dropped
        run_op(1'b0, '0, R, 50, A5);
        check("ign timeout", 128'(timeout), 128'd0);
        check("ign done_cycle", 128'(done_cyc), 128'd147);
        check("ign done_count", 128'(done_cnt), 128'd1);
        check("ign start_count", 128'(start_cnt), 128'd1);
        check("ign chal_stable", 128'(chal_bad), 128'd0);
        check("ign distance", 128'(distance), 128'd0);
        check("ign pass", 128'(pass), 128'd1);
        repeat (3) @(negedge clk);
        check("ign no_late_op", 128'(busy), 128'd0);
        check("ign idle_chal", puf_challenge, A5);

        for (int i = 7; i < 10; i++) apply_vec(i);

        // Authenticate then reset at cycle 100
        @(negedge clk);
        req          = 1'b1;
        enroll       = 1'b0;
        puf_response = ~R;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        chal_bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) chal_bad++;
        end
        check("midrst no_done", 128'(done_cnt), 128'd0);
        check("midrst no_busy", 128'(chal_bad), 128'd0);

        // Stored reference is gone after reset
        apply_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_verifier.md
# puf_verifier

Challenge-issuing and response-checking controller for the PUF array, on the opposite end of the challenge/response exchange. It drives `start` and the N-bit challenge into the PUF array and waits a fixed settle window. It then captures the N-bit response and either enrolls it as the golden reference or authenticates it against the stored reference by serial Hamming distance against a threshold. It sits between the host/security logic and the `puf` block instance.

## Interface
- `N`, 128: challenge/response width; must match the PUF array.
- `WAIT_CYCLES`, 16: cycles between PUF launch and response capture; ≥1.
- `THRESH`, 12: maximum Hamming distance that still passes; 0..N.
- `DW`, $clog2(N+1): distance width (derived, not overridden).

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  start an operation; sampled only in IDLE.
- `enroll`  in  1  with `req`: 1 = enroll, 0 = authenticate.
- `chal_in`  in  N  challenge to enroll; captured with `req` when `enroll`=1, ignored otherwise.
- `puf_start`  out  1  one-cycle launch pulse to the PUF array.
- `puf_challenge`  out  N  challenge driven to the PUF array.
- `puf_response`  in  N  PUF array response.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  authentication verdict; valid from `done`, held until the next accepted `req`.
- `error`  out  1  authenticate requested with no enrollment; same validity as `pass`.
- `distance`  out  DW  Hamming distance of the last authentication; same validity as `pass`.
- `enrolled`  out  1  a reference pair is stored.

## Operation
- Storage:
  - `ref_chal` (N): stored challenge.
  - `ref_resp` (N): stored response.
  - `enrolled` flag.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE, COMPARE, DONE.
- IDLE, `req`=1, `enroll`=1:
  - `puf_challenge` <= `chal_in`.
  - Clear `pass`/`error`/`distance`.
  - Go to LAUNCH.
- IDLE, `req`=1, `enroll`=0, `enrolled`=1:
  - `puf_challenge` <= `ref_chal`.
  - Clear `pass`/`error`/`distance`.
  - Go to LAUNCH.
- IDLE, `req`=1, `enroll`=0, `enrolled`=0:
  - Go directly to DONE with `error`=1, `pass`=0, `distance`=0.
- LAUNCH:
  - `puf_start`=1 for exactly this cycle.
  - Load the wait counter with WAIT_CYCLES-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - At 0, go to CAPTURE.
  - Total time in WAIT is WAIT_CYCLES cycles.
- CAPTURE:
  - Register `puf_response` into `cap_resp`.
  - Enroll: `ref_resp` <= `puf_response`, `ref_chal` <= `puf_challenge`, `enrolled` <= 1; go to DONE.
  - Authenticate: clear the accumulator and bit index; go to COMPARE.
- COMPARE:
  - One bit per cycle, index i = 0..N-1: accumulator += `cap_resp[i]` ^ `ref_resp[i]`.
  - After bit N-1, go to DONE.
  - The accumulator is DW bits and never overflows (max N).
- DONE:
  - `done`=1.
  - Authenticate: `distance` <= accumulator; `pass` <= (accumulator ≤ THRESH).
  - Enroll: `pass`=0, `error`=0.
  - Go to IDLE.
- `puf_challenge` is held stable from LAUNCH through CAPTURE and retains its value in IDLE.
- `req` outside IDLE is ignored, not queued.
- Re-enrolling overwrites the stored pair.

## Timing
- Reset values:
  - `busy`, `done`, `pass`, `error`, `puf_start`, `enrolled` = 0.
  - `distance` = 0.
  - `puf_challenge`, `ref_chal`, `ref_resp`, `cap_resp` = 0.
  - State = IDLE.
- Reset is honored mid-operation. Any state returns to IDLE immediately, and the stored reference is lost (`enrolled`=0).
- Cycle 0 is the edge where `req` is sampled in IDLE.
- `puf_challenge` is valid and `puf_start`=1 in cycle 1.
- `puf_response` is sampled at the end of cycle WAIT_CYCLES+2.
- Enroll: `done` in cycle WAIT_CYCLES+3 (19 with defaults).
- Authenticate: `done` in cycle WAIT_CYCLES+3+N (147 with defaults).
- Authenticate without enrollment: `done` in cycle 1, with `busy`=1 only in that cycle.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- A new `req` is accepted no earlier than that cycle.
- `pass`, `error` and `distance` update in the `done` cycle and stay stable until the next accepted `req`.

## Test plan
- Reset, then enroll with `chal_in`=0xA5…A5 and `puf_response`=R:
  - `puf_start` pulses once in cycle 1, `done` in cycle 19, `enrolled`=1.
  - `puf_challenge` stays 0xA5…A5 throughout.
- Authenticate with `puf_response`=R:
  - `puf_challenge`=0xA5…A5, `done` in cycle 147.
  - `distance`=0, `pass`=1, `error`=0.
- Authenticate with R⊕(5 bits set) → `distance`=5, `pass`=1.
- Authenticate with R⊕(13 bits set) → `distance`=13, `pass`=0.
- Authenticate with R inverted → `distance`=128, `pass`=0.
- Authenticate right after reset:
  - `done` in cycle 1, `error`=1, `pass`=0.
  - No `puf_start` pulse.
- Enroll, then authenticate:
  - Pulse `req` again at cycle 50 (ignored; single `done`).
  - Assert `rst` at cycle 100 of a second authenticate.
  - Required: all outputs return to reset values asynchronously; `enrolled`=0; no `done` follows.
